// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline front-end hazard control.
//   hz_state_t   : sequencer state (RUN = normal/detecting, HOLD = extended stall)
//   REG_ZERO     : register specifier of $zero, which never creates a dependency
//   HZ_LEN_*     : hazard lengths reported by hazard_detect (stall cycles needed)
package mips_pipe_pkg;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_t;

  localparam int REG_ZERO = 0;

  localparam logic [1:0] HZ_LEN_NONE = 2'd0;
  localparam logic [1:0] HZ_LEN_ONE  = 2'd1;
  localparam logic [1:0] HZ_LEN_TWO  = 2'd2;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between ID/EX decode logic and the hazard sequencer.
//   Inputs to the sequencer : ID operand fields/usage, branch info, EX load/write/dest,
//                             imem_wait
//   Outputs of the sequencer: pc_le, if_id_le, id_ex_bubble, pc_src_sel, stall_active,
//                             stall_cycles (saturating hazard-stall counter)
//   master : the pipeline side driving decode info
//   slave  : the hazard_stall_ctrl block
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             id_branch_taken;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [REG_W-1:0] ex_dest;
  logic             imem_wait;

  logic             pc_le;
  logic             if_id_le;
  logic             id_ex_bubble;
  logic             pc_src_sel;
  logic             stall_active;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
           ex_mem_read, ex_reg_write, ex_dest, imem_wait,
    input  pc_le, if_id_le, id_ex_bubble, pc_src_sel, stall_active, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
           ex_mem_read, ex_reg_write, ex_dest, imem_wait,
    output pc_le, if_id_le, id_ex_bubble, pc_src_sel, stall_active, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl_detect.sv
// hazard_detect: purely combinational comparison of the ID instruction's source
// operands against the EX destination; reports how many stall cycles are needed.
//   id_rs/id_rt, id_uses_rs/id_uses_rt, id_is_branch : ID instruction info
//   ex_mem_read, ex_reg_write, ex_dest               : EX instruction info
//   hz_len_o                                         : 0, 1 or 2 stall cycles
module hazard_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dest,
  output logic [1:0]       hz_len_o
);
  logic dest_live;
  logic m_rs;
  logic m_rt;
  logic dep;

  // Writes to $zero are discarded, so they never produce a dependency.
  assign dest_live = (ex_dest != REG_W'(REG_ZERO));
  assign m_rs      = dest_live && id_uses_rs && (ex_dest == id_rs);
  assign m_rt      = dest_live && id_uses_rt && (ex_dest == id_rt);
  assign dep       = m_rs || m_rt;

  always_comb begin
    hz_len_o = HZ_LEN_NONE;
    if (dep) begin
      if (ex_mem_read) begin
        // Branches compare in ID, so a load feeding them needs one extra cycle.
        hz_len_o = id_is_branch ? HZ_LEN_TWO : HZ_LEN_ONE;
      end else if (ex_reg_write && id_is_branch) begin
        hz_len_o = HZ_LEN_ONE;
      end
    end
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline front-end sequencer. Holds PC and IF/ID and inserts
// ID/EX bubbles for load-use / branch-operand hazards (1-2 cycles), freezes on
// instruction-memory wait, and counts hazard stall cycles (saturating).
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : hazard_stall_ctrl_if.slave (decode/EX info in, pipeline controls out)
module hazard_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
);
  hz_state_t        state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [1:0]       hz_len;
  logic             stall;
  logic             stall_eff;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_uses_rs   (bus.id_uses_rs),
    .id_uses_rt   (bus.id_uses_rt),
    .id_is_branch (bus.id_is_branch),
    .ex_mem_read  (bus.ex_mem_read),
    .ex_reg_write (bus.ex_reg_write),
    .ex_dest      (bus.ex_dest),
    .hz_len_o     (hz_len)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    // imem_wait freezes the sequencer entirely; detection is ignored.
    if (!bus.imem_wait) begin
      case (state_q)
        HZ_RUN: begin
          if (hz_len != HZ_LEN_NONE) begin
            stall = 1'b1;
            if (hz_len == HZ_LEN_TWO) begin
              cnt_d   = 2'd1;
              state_d = HZ_HOLD;
            end
          end
        end
        HZ_HOLD: begin
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = HZ_RUN;
          end
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  assign stall_eff = stall && !reset;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_eff && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= HZ_RUN;
      cnt_q          <= 2'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Reset and imem_wait both hold the front end with a bubble but are not
  // hazard stalls; a taken branch is deferred while any hold is in effect.
  always_comb begin
    bus.pc_le        = 1'b1;
    bus.if_id_le     = 1'b1;
    bus.id_ex_bubble = 1'b0;
    bus.pc_src_sel   = bus.id_branch_taken;
    bus.stall_active = 1'b0;
    if (reset || bus.imem_wait || stall) begin
      bus.pc_le        = 1'b0;
      bus.if_id_le     = 1'b0;
      bus.id_ex_bubble = 1'b1;
      bus.pc_src_sel   = 1'b0;
      bus.stall_active = stall_eff && !bus.imem_wait;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized + directed bench for hazard_stall_ctrl. Two instances (16-bit and
// 4-bit stall counters) receive identical stimulus; a behavioural model tracks
// "remaining forced stall cycles" and the total hazard stall count.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_dest = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, id_is_branch = 0, id_branch_taken = 0;
  logic ex_mem_read = 0, ex_reg_write = 0, imem_wait = 0;

  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) bus16 ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  bus4 ();

  assign bus16.id_rs = id_rs;           assign bus4.id_rs = id_rs;
  assign bus16.id_rt = id_rt;           assign bus4.id_rt = id_rt;
  assign bus16.id_uses_rs = id_uses_rs; assign bus4.id_uses_rs = id_uses_rs;
  assign bus16.id_uses_rt = id_uses_rt; assign bus4.id_uses_rt = id_uses_rt;
  assign bus16.id_is_branch = id_is_branch;       assign bus4.id_is_branch = id_is_branch;
  assign bus16.id_branch_taken = id_branch_taken; assign bus4.id_branch_taken = id_branch_taken;
  assign bus16.ex_mem_read = ex_mem_read;   assign bus4.ex_mem_read = ex_mem_read;
  assign bus16.ex_reg_write = ex_reg_write; assign bus4.ex_reg_write = ex_reg_write;
  assign bus16.ex_dest = ex_dest;           assign bus4.ex_dest = ex_dest;
  assign bus16.imem_wait = imem_wait;       assign bus4.imem_wait = imem_wait;

  hazard_stall_ctrl #(.REG_W(5), .CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  hazard_stall_ctrl #(.REG_W(5), .CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state: stall cycles still owed and total hazard stall cycles.
  int      m_owed = 0;
  longint  m_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic int hazard_len();
    bit dep;
    dep = (ex_dest != 0) &&
          ((id_uses_rs && ex_dest == id_rs) || (id_uses_rt && ex_dest == id_rt));
    if (!dep) return 0;
    if (ex_mem_read) return id_is_branch ? 2 : 1;
    if (ex_reg_write && id_is_branch) return 1;
    return 0;
  endfunction

  task automatic step(input bit rst, input bit wt, input bit [4:0] rs, input bit [4:0] rt,
                      input bit urs, input bit urt, input bit br, input bit tk,
                      input bit mr, input bit rw, input bit [4:0] dst);
    int  n;
    bit  stall;
    logic [4:0] exp_outs, got16, got4;
    longint e16, e4;
    @(posedge clk); #1;
    reset = rst; imem_wait = wt; id_rs = rs; id_rt = rt; id_uses_rs = urs;
    id_uses_rt = urt; id_is_branch = br; id_branch_taken = tk;
    ex_mem_read = mr; ex_reg_write = rw; ex_dest = dst;
    n = hazard_len();
    stall = 0;
    if (!rst && !wt) stall = (m_owed > 0) || (n > 0);
    // {pc_le, if_id_le, id_ex_bubble, pc_src_sel, stall_active}
    if (rst || wt)  exp_outs = 5'b00100;
    else if (stall) exp_outs = 5'b00101;
    else            exp_outs = {4'b1100, 1'b0} | {3'b000, tk, 1'b0};
    e16 = (m_total > 65535) ? 65535 : m_total;
    e4  = (m_total > 15) ? 15 : m_total;
    @(negedge clk);
    got16 = {bus16.pc_le, bus16.if_id_le, bus16.id_ex_bubble, bus16.pc_src_sel, bus16.stall_active};
    got4  = {bus4.pc_le, bus4.if_id_le, bus4.id_ex_bubble, bus4.pc_src_sel, bus4.stall_active};
    check("ctrl16", {27'd0, got16}, {27'd0, exp_outs});
    check("ctrl4",  {27'd0, got4},  {27'd0, exp_outs});
    check("cnt16",  {16'd0, bus16.stall_cycles}, e16[31:0]);
    check("cnt4",   {28'd0, bus4.stall_cycles},  e4[31:0]);
    // Commit what the DUT registers at the coming rising edge.
    if (rst) begin
      m_owed = 0; m_total = 0;
    end else if (!wt && stall) begin
      if (m_owed > 0) m_owed--;
      else m_owed = n - 1;
      m_total++;
    end
    cyc++;
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle(1); idle(1); idle(0);
    // load-use: lw $5 / add rs=$5
    step(0, 0, 5, 3, 1, 1, 0, 0, 1, 1, 5);
    idle(0);
    // lw $5 / beq rs=$5 taken: two stalls then redirect
    step(0, 0, 5, 2, 1, 1, 1, 1, 1, 1, 5);
    step(0, 0, 5, 2, 1, 1, 1, 1, 0, 0, 0);
    step(0, 0, 5, 2, 1, 1, 1, 1, 0, 0, 0);
    // ALU -> branch rt, then $zero match
    step(0, 0, 1, 7, 1, 1, 1, 0, 0, 1, 7);
    step(0, 0, 0, 4, 1, 1, 1, 1, 1, 1, 0);
    // imem_wait for 3 cycles inside HOLD
    step(0, 0, 6, 2, 1, 1, 1, 0, 1, 1, 6);
    repeat (3) step(0, 1, 6, 2, 1, 1, 1, 0, 1, 1, 6);
    step(0, 0, 6, 2, 1, 1, 1, 1, 0, 0, 0);
    idle(0);
    // reset inside HOLD
    step(0, 0, 3, 2, 1, 1, 1, 0, 1, 1, 3);
    idle(1);
    idle(0);
    // saturate the 4-bit counter
    repeat (20) step(0, 0, 9, 0, 1, 0, 0, 0, 1, 1, 9);
    idle(0);
    // randomized traffic with small register range to hit hazards often
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
